// File: rtl/instr_fetch_unit.sv
// Instruction fetch initiator: drives the single-cycle instruction ROM, buffers
// returned words with their PCs in a small prefetch FIFO and hands them to decode.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 4,
    parameter int                    ROM_BYTES  = 8192
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  rom_en_n,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    output logic                  fetch_fault_o,
    output logic [ADDR_WIDTH-1:0] fault_pc_o
);

    localparam int                    PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                    CNT_W     = PTR_W + 1;
    localparam logic [CNT_W:0]        DEPTH_C   = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0]   ROM_LIMIT = (ADDR_WIDTH+1)'(ROM_BYTES);

    typedef enum logic {RUN, FAULT} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] word;
    } entry_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic                  req_valid;
    entry_t                fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                  in_range;
    logic [CNT_W:0]        pending;
    logic                  credit;
    logic                  issue;
    logic                  oor_hit;
    logic                  push;
    logic                  pop;

    // Credit counts buffered plus in-flight words from registered state only, so a
    // push can never land on a full FIFO regardless of what decode does this cycle.
    always_comb begin
        in_range = ({1'b0, fetch_pc} < ROM_LIMIT);
        pending  = {1'b0, count} + {{CNT_W{1'b0}}, req_valid};
        credit   = (pending < DEPTH_C);
        issue    = reset_n & (state == RUN) & in_range & credit & ~redirect_i;
        oor_hit  = (state == RUN) & ~in_range & credit & ~redirect_i;
        push     = req_valid;
        pop      = instr_valid_o & instr_ready_i;
    end

    assign rom_en_n      = ~issue;
    assign rom_addr_o    = fetch_pc;
    assign instr_valid_o = (count != '0);
    assign instr_o       = fifo_q[rd_ptr].word;
    assign instr_pc_o    = fifo_q[rd_ptr].pc;
    assign fetch_fault_o = (state == FAULT) & (count == '0) & ~req_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            fetch_pc   <= RESET_PC;
            req_pc     <= RESET_PC;
            req_valid  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fault_pc_o <= '0;
        end else if (redirect_i) begin
            // Flush: buffered and in-flight words are dropped, fetch restarts aligned.
            state     <= RUN;
            fetch_pc  <= {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
            req_valid <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            req_valid <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                req_pc   <= fetch_pc;
            end
            if (oor_hit) begin
                state      <= FAULT;
                fault_pc_o <= fetch_pc;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by count and the pointers.
    always_ff @(posedge clk) begin
        if (push && !redirect_i) begin
            fifo_q[wr_ptr] <= '{pc: req_pc, word: rom_data_i};
        end
    end

endmodule
